// File: rtl/mem_stage_lsu.sv
// ---------------------------------------------------------------------------
// mem_stage_lsu
//   Memory-access stage of the 5-stage RISC-V pipeline. It takes the EX/MEM
//   register outputs and drives the data-memory req/gnt/rvalid port. It
//   generates byte enables and replicates store data across byte lanes, and it
//   aligns and sign/zero-extends load data. While an access is outstanding it
//   stalls the upstream stages. It also owns the MEM/WB pipeline register.
//
//   Optional feature: define MEM_MISALIGN_TRAP_EN to trap misaligned
//   halfword/word accesses. A trapped access issues no memory request, writes
//   no register and pulses MisalignOut for one cycle. Without the macro, the
//   ignored low address bits force alignment.
//
// Ports
//   clk, rst                 clock; asynchronous active-low reset
//   MemAddrIn..RegDstIn      EX/MEM register outputs (address, store data,
//                            imm, PC, funct3, mem enables, WB control, rd)
//   DmReq/DmWe/DmAddr/
//   DmWdata/DmBe             data-memory request (combinational)
//   DmGnt/DmRvalid/DmRdata   data-memory response
//   MemStall                 hold EX/MEM and upstream stages (combinational)
//   ALUResultOut..RegDstOut  MEM/WB register outputs
//   MisalignOut              misaligned-access pulse (MEM_MISALIGN_TRAP_EN only)
// ---------------------------------------------------------------------------
module mem_stage_lsu #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned INS_ADDRESS = 9,
    parameter int unsigned DM_ADDRESS  = 9
) (
    input  logic                   clk,
    input  logic                   rst,
    // EX/MEM inputs
    input  logic [DATA_W-1:0]      MemAddrIn,
    input  logic [DATA_W-1:0]      MemWrtDataIn,
    input  logic [DATA_W-1:0]      immIn,
    input  logic [INS_ADDRESS-1:0] PCin,
    input  logic [2:0]             funct3In,
    input  logic                   MemWrtEnIn,
    input  logic                   MemRdEnIn,
    input  logic                   RegWrtEnIn,
    input  logic [2:0]             RegWrtSrcIn,
    input  logic [4:0]             RegDstIn,
    // data-memory port
    output logic                   DmReq,
    output logic                   DmWe,
    output logic [DM_ADDRESS-1:0]  DmAddr,
    output logic [DATA_W-1:0]      DmWdata,
    output logic [3:0]             DmBe,
    input  logic                   DmGnt,
    input  logic                   DmRvalid,
    input  logic [DATA_W-1:0]      DmRdata,
    // pipeline control
    output logic                   MemStall,
    // MEM/WB register
    output logic [DATA_W-1:0]      ALUResultOut,
    output logic [DATA_W-1:0]      immOut,
    output logic [INS_ADDRESS-1:0] PCout,
    output logic [DATA_W-1:0]      RdDataOut,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic                   MisalignOut,
`endif
    output logic                   RegWrtEnOut,
    output logic [2:0]             RegWrtSrcOut,
    output logic [4:0]             RegDstOut
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned HALF_W = 16;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_WAIT_RD = 1'b1
    } state_t;

    state_t state_q, state_d;

    // Access decode: a store wins when both enables are set.
    logic is_store;
    logic is_load;
    logic access;

    assign is_store = MemWrtEnIn;
    assign is_load  = MemRdEnIn & ~MemWrtEnIn;
    assign access   = MemWrtEnIn | MemRdEnIn;

    // Misaligned halfword/word detection (trap build only).
    logic misalign;
`ifdef MEM_MISALIGN_TRAP_EN
    logic mis_half;
    logic mis_word;

    always_comb begin
        mis_half = is_store ? (funct3In == F3_H)
                            : ((funct3In == F3_H) || (funct3In == F3_HU));
        mis_word = (funct3In == F3_W);
        misalign = access & ((mis_half & MemAddrIn[0]) |
                             (mis_word & (MemAddrIn[1:0] != 2'b00)));
    end
`else
    assign misalign = 1'b0;
`endif

    // Store lane steering; loads always read the full word.
    logic [3:0]        be_c;
    logic [DATA_W-1:0] wdata_c;

    always_comb begin
        be_c    = 4'b1111;
        wdata_c = MemWrtDataIn;
        if (is_store) begin
            case (funct3In)
                F3_B: begin
                    be_c    = 4'b0001 << MemAddrIn[1:0];
                    wdata_c = {4{MemWrtDataIn[BYTE_W-1:0]}};
                end
                F3_H: begin
                    be_c    = 4'b0011 << {MemAddrIn[1], 1'b0};
                    wdata_c = {2{MemWrtDataIn[HALF_W-1:0]}};
                end
                default: ;
            endcase
        end
    end

    // FSM next state and per-cycle control.
    logic dm_req_c;
    logic stall_c;
    logic wb_load_c;   // MEM/WB captures the current EX/MEM slot
    logic rd_take_c;   // captured slot carries returned load data
    logic grant_c;     // load accepted: remember its offset and size
    logic trap_c;

    always_comb begin
        state_d   = state_q;
        dm_req_c  = 1'b0;
        stall_c   = 1'b0;
        wb_load_c = 1'b0;
        rd_take_c = 1'b0;
        grant_c   = 1'b0;
        trap_c    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (misalign) begin
                    trap_c    = 1'b1;
                    wb_load_c = 1'b1;
                end else if (access) begin
                    dm_req_c = 1'b1;
                    if (!DmGnt) begin
                        stall_c = 1'b1;
                    end else if (is_load) begin
                        stall_c = 1'b1;
                        grant_c = 1'b1;
                        state_d = S_WAIT_RD;
                    end else begin
                        wb_load_c = 1'b1;
                    end
                end else begin
                    wb_load_c = 1'b1;
                end
            end
            S_WAIT_RD: begin
                if (DmRvalid) begin
                    wb_load_c = 1'b1;
                    rd_take_c = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    stall_c = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Offset and size of the outstanding load, frozen at grant.
    logic [1:0] off_q;
    logic [2:0] f3_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            off_q <= 2'b00;
            f3_q  <= 3'b000;
        end else if (grant_c) begin
            off_q <= MemAddrIn[1:0];
            f3_q  <= funct3In;
        end
    end

    // Load align and extend.
    logic [BYTE_W-1:0] byte_c;
    logic [HALF_W-1:0] half_c;
    logic [DATA_W-1:0] ld_data_c;

    always_comb begin
        byte_c = DmRdata[7:0];
        case (off_q)
            2'd1:    byte_c = DmRdata[15:8];
            2'd2:    byte_c = DmRdata[23:16];
            2'd3:    byte_c = DmRdata[31:24];
            default: ;
        endcase
        half_c    = off_q[1] ? DmRdata[31:16] : DmRdata[15:0];
        ld_data_c = DmRdata;
        case (f3_q)
            F3_B:    ld_data_c = {{(DATA_W-BYTE_W){byte_c[BYTE_W-1]}}, byte_c};
            F3_BU:   ld_data_c = {{(DATA_W-BYTE_W){1'b0}}, byte_c};
            F3_H:    ld_data_c = {{(DATA_W-HALF_W){half_c[HALF_W-1]}}, half_c};
            F3_HU:   ld_data_c = {{(DATA_W-HALF_W){1'b0}}, half_c};
            default: ;
        endcase
    end

    // MEM/WB register: capture on progress, otherwise insert a bubble.
    logic [DATA_W-1:0]      alu_q,   alu_d;
    logic [DATA_W-1:0]      imm_q,   imm_d;
    logic [INS_ADDRESS-1:0] pc_q,    pc_d;
    logic [DATA_W-1:0]      rdata_q, rdata_d;
    logic                   rwe_q,   rwe_d;
    logic [2:0]             src_q,   src_d;
    logic [4:0]             dst_q,   dst_d;

    always_comb begin
        alu_d   = alu_q;
        imm_d   = imm_q;
        pc_d    = pc_q;
        rdata_d = rdata_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rwe_d   = 1'b0;
        if (wb_load_c) begin
            alu_d   = MemAddrIn;
            imm_d   = immIn;
            pc_d    = PCin;
            rdata_d = rd_take_c ? ld_data_c : '0;
            src_d   = RegWrtSrcIn;
            dst_d   = RegDstIn;
            rwe_d   = RegWrtEnIn & ~trap_c;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_q   <= '0;
            imm_q   <= '0;
            pc_q    <= '0;
            rdata_q <= '0;
            rwe_q   <= 1'b0;
            src_q   <= 3'b000;
            dst_q   <= 5'b00000;
        end else begin
            alu_q   <= alu_d;
            imm_q   <= imm_d;
            pc_q    <= pc_d;
            rdata_q <= rdata_d;
            rwe_q   <= rwe_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    logic mis_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mis_q <= 1'b0;
        end else begin
            mis_q <= trap_c;
        end
    end

    assign MisalignOut = mis_q;
`endif

    // Memory port; the request is forced low while reset is asserted.
    assign DmReq   = dm_req_c & rst;
    assign DmWe    = is_store;
    assign DmAddr  = MemAddrIn[DM_ADDRESS+1:2];
    assign DmWdata = wdata_c;
    assign DmBe    = be_c;
    assign MemStall = stall_c & rst;

    assign ALUResultOut = alu_q;
    assign immOut       = imm_q;
    assign PCout        = pc_q;
    assign RdDataOut    = rdata_q;
    assign RegWrtEnOut  = rwe_q;
    assign RegWrtSrcOut = src_q;
    assign RegDstOut    = dst_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned INS_ADDRESS = 9;
    localparam int unsigned DM_ADDRESS  = 9;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [DATA_W-1:0]      MemAddrIn;
    logic [DATA_W-1:0]      MemWrtDataIn;
    logic [DATA_W-1:0]      immIn;
    logic [INS_ADDRESS-1:0] PCin;
    logic [2:0]             funct3In;
    logic                   MemWrtEnIn;
    logic                   MemRdEnIn;
    logic                   RegWrtEnIn;
    logic [2:0]             RegWrtSrcIn;
    logic [4:0]             RegDstIn;
    logic                   DmReq;
    logic                   DmWe;
    logic [DM_ADDRESS-1:0]  DmAddr;
    logic [DATA_W-1:0]      DmWdata;
    logic [3:0]             DmBe;
    logic                   DmGnt;
    logic                   DmRvalid;
    logic [DATA_W-1:0]      DmRdata;
    logic                   MemStall;
    logic [DATA_W-1:0]      ALUResultOut;
    logic [DATA_W-1:0]      immOut;
    logic [INS_ADDRESS-1:0] PCout;
    logic [DATA_W-1:0]      RdDataOut;
    logic                   RegWrtEnOut;
    logic [2:0]             RegWrtSrcOut;
    logic [4:0]             RegDstOut;
`ifdef MEM_MISALIGN_TRAP_EN
    logic                   MisalignOut;
`endif

    mem_stage_lsu #(
        .DATA_W      (DATA_W),
        .INS_ADDRESS (INS_ADDRESS),
        .DM_ADDRESS  (DM_ADDRESS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .MemAddrIn    (MemAddrIn),
        .MemWrtDataIn (MemWrtDataIn),
        .immIn        (immIn),
        .PCin         (PCin),
        .funct3In     (funct3In),
        .MemWrtEnIn   (MemWrtEnIn),
        .MemRdEnIn    (MemRdEnIn),
        .RegWrtEnIn   (RegWrtEnIn),
        .RegWrtSrcIn  (RegWrtSrcIn),
        .RegDstIn     (RegDstIn),
        .DmReq        (DmReq),
        .DmWe         (DmWe),
        .DmAddr       (DmAddr),
        .DmWdata      (DmWdata),
        .DmBe         (DmBe),
        .DmGnt        (DmGnt),
        .DmRvalid     (DmRvalid),
        .DmRdata      (DmRdata),
        .MemStall     (MemStall),
        .ALUResultOut (ALUResultOut),
        .immOut       (immOut),
        .PCout        (PCout),
        .RdDataOut    (RdDataOut),
`ifdef MEM_MISALIGN_TRAP_EN
        .MisalignOut  (MisalignOut),
`endif
        .RegWrtEnOut  (RegWrtEnOut),
        .RegWrtSrcOut (RegWrtSrcOut),
        .RegDstOut    (RegDstOut)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        re;
        logic        rwe;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rdata;
        int          gnt;        // cycles of DmReq before DmGnt
        int          rv;         // cycles from DmGnt to DmRvalid (loads)
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rd;
        int          exp_stalls;
    } vec_t;

    typedef struct {
        logic [31:0]            alu;
        logic [31:0]            imm;
        logic [INS_ADDRESS-1:0] pc;
        logic [31:0]            rd;
        logic [2:0]             src;
        logic [4:0]             dst;
    } wb_t;

    int   checks = 0;
    int   errors = 0;
    int   wb_n   = 0;
    wb_t  sb[$];
    wb_t  mon_e;
    vec_t vecs[$];
    logic [31:0] prev_alu;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic re, input logic rwe,
                                input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [31:0] rdata,
                                input int gnt, input int rv, input logic [3:0] be,
                                input logic [31:0] ewd, input logic [31:0] erd,
                                input int st);
        vec_t v;
        v.we = we; v.re = re; v.rwe = rwe; v.f3 = f3; v.addr = addr; v.wd = wd;
        v.rdata = rdata; v.gnt = gnt; v.rv = rv; v.exp_be = be; v.exp_wdata = ewd;
        v.exp_rd = erd; v.exp_stalls = st;
        return v;
    endfunction

    task automatic drive_idle();
        MemAddrIn = '0; MemWrtDataIn = '0; immIn = '0; PCin = '0; funct3In = 3'b000;
        MemWrtEnIn = 1'b0; MemRdEnIn = 1'b0; RegWrtEnIn = 1'b0;
        RegWrtSrcIn = 3'b000; RegDstIn = 5'b00000; DmGnt = 1'b0; DmRvalid = 1'b0;
    endtask

    // Drives one EX/MEM slot, plays the memory, checks the port each cycle.
    task automatic run_op(input vec_t v, input int idx);
        logic is_acc;
        logic is_load;
        logic in_wait;
        logic done;
        int   k;
        int   r;
        int   stalls;
        wb_t  e;
        is_acc  = v.we | v.re;
        is_load = v.re & ~v.we;
        in_wait = 1'b0;
        done    = 1'b0;
        k = 0; r = 0; stalls = 0;
        MemAddrIn    = v.addr;
        MemWrtDataIn = v.wd;
        immIn        = 32'hA000_0000 | 32'(idx);
        PCin         = INS_ADDRESS'(idx * 4 + 16);
        funct3In     = v.f3;
        MemWrtEnIn   = v.we;
        MemRdEnIn    = v.re;
        RegWrtEnIn   = v.rwe;
        RegWrtSrcIn  = 3'(idx % 8);
        RegDstIn     = 5'(idx + 1);
        DmRdata      = v.rdata;
        DmGnt        = is_acc && (v.gnt == 0);
        DmRvalid     = 1'b0;
        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            @(negedge clk);
            check($sformatf("v%0d_alu_hold", idx), ALUResultOut, prev_alu);
            if (!in_wait) begin
                check($sformatf("v%0d_req", idx), 32'(DmReq), 32'(is_acc));
                if (is_acc) begin
                    check($sformatf("v%0d_we", idx), 32'(DmWe), 32'(v.we));
                    check($sformatf("v%0d_addr", idx), 32'(DmAddr), v.addr >> 2);
                    check($sformatf("v%0d_be", idx), 32'(DmBe), 32'(v.exp_be));
                    if (v.we) check($sformatf("v%0d_wdata", idx), DmWdata, v.exp_wdata);
                end
                if (!is_acc || (DmGnt && !is_load)) begin
                    done = 1'b1;
                    check($sformatf("v%0d_stall", idx), 32'(MemStall), 0);
                end else begin
                    check($sformatf("v%0d_stall", idx), 32'(MemStall), 1);
                    stalls++;
                    if (DmGnt) in_wait = 1'b1;
                    else k++;
                end
            end else begin
                check($sformatf("v%0d_req_wait", idx), 32'(DmReq), 0);
                if (DmRvalid) begin
                    done = 1'b1;
                    check($sformatf("v%0d_stall", idx), 32'(MemStall), 0);
                end else begin
                    check($sformatf("v%0d_stall", idx), 32'(MemStall), 1);
                    stalls++;
                    r++;
                end
            end
            if (done && v.rwe) begin
                e.alu = v.addr; e.imm = immIn; e.pc = PCin; e.rd = v.exp_rd;
                e.src = RegWrtSrcIn; e.dst = RegDstIn;
                sb.push_back(e);
            end
            @(posedge clk); #1;
            DmGnt    = !in_wait && is_acc && !done && (k == v.gnt);
            DmRvalid = in_wait && !done && (r == v.rv - 1);
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL v%0d_timeout: access did not complete within 64 cycles", idx);
        end
        check($sformatf("v%0d_stall_count", idx), 32'(stalls), 32'(v.exp_stalls));
        prev_alu = v.addr;
        drive_idle();
    endtask

    // Scoreboard: every register write must match the oldest completed slot.
    always @(negedge clk) begin
        if (RegWrtEnOut === 1'b1) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL wb_unexpected: write to x%0d got 0x%08h expected no write", RegDstOut, RdDataOut);
            end else begin
                mon_e = sb.pop_front();
                check($sformatf("wb%0d_alu", wb_n), ALUResultOut, mon_e.alu);
                check($sformatf("wb%0d_imm", wb_n), immOut, mon_e.imm);
                check($sformatf("wb%0d_pc", wb_n), 32'(PCout), 32'(mon_e.pc));
                check($sformatf("wb%0d_rdata", wb_n), RdDataOut, mon_e.rd);
                check($sformatf("wb%0d_src", wb_n), 32'(RegWrtSrcOut), 32'(mon_e.src));
                check($sformatf("wb%0d_dst", wb_n), 32'(RegDstOut), 32'(mon_e.dst));
                wb_n++;
            end
        end
    end

    initial begin
        rst = 1'b0;
        drive_idle();
        DmRdata   = '0;
        MemRdEnIn = 1'b1;   // request must stay low while in reset
        prev_alu  = '0;
        repeat (2) @(negedge clk);
        check("reset_req", 32'(DmReq), 0);
        check("reset_stall", 32'(MemStall), 0);
        check("reset_rwe", 32'(RegWrtEnOut), 0);
        check("reset_rdata", RdDataOut, 0);
        check("reset_alu", ALUResultOut, 0);
        check("reset_pc", 32'(PCout), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        drive_idle();

        //                 we    re    rwe   f3      addr      wdata          rdata          gnt rv be       exp_wdata      exp_rd         st
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 3'b010, 32'h104, 32'hDEADBEEF, 32'h0,         0, 0, 4'b1111, 32'hDEADBEEF, 32'h0,         0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 3'b000, 32'h103, 32'h123456AB, 32'h0,         0, 0, 4'b1000, 32'hABABABAB, 32'h0,         0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 3'b001, 32'h102, 32'h0000BEEF, 32'h0,         1, 0, 4'b1100, 32'hBEEFBEEF, 32'h0,         1));
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 3'b000, 32'h003, 32'h0,        32'h80FF0000,  0, 1, 4'b1111, 32'h0,        32'hFFFFFF80,  1));
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 3'b101, 32'h002, 32'h0,        32'h80FF0000,  3, 2, 4'b1111, 32'h0,        32'h000080FF,  5));
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 3'b010, 32'h008, 32'h0,        32'h12345678,  1, 1, 4'b1111, 32'h0,        32'h12345678,  2));
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 3'b001, 32'h000, 32'h0,        32'h00008001,  0, 3, 4'b1111, 32'h0,        32'hFFFF8001,  3));
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 3'b100, 32'h001, 32'h0,        32'h00009A00,  2, 1, 4'b1111, 32'h0,        32'h0000009A,  3));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 3'b000, 32'h055, 32'h0,        32'h0,         0, 0, 4'b1111, 32'h0,        32'h0,         0));
        vecs.push_back(mk(1'b1, 1'b1, 1'b1, 3'b010, 32'h010, 32'h0BADF00D, 32'hFFFFFFFF,  2, 0, 4'b1111, 32'h0BADF00D, 32'h0,         2));
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 3'b000, 32'h002, 32'h0,        32'h007F0000,  0, 1, 4'b1111, 32'h0,        32'h0000007F,  1));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 3'b011, 32'h020, 32'hCAFEF00D, 32'h0,         1, 0, 4'b1111, 32'hCAFEF00D, 32'h0,         1));
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 3'b110, 32'h024, 32'h0,        32'h13579BDF,  0, 2, 4'b1111, 32'h0,        32'h13579BDF,  2));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 3'b000, 32'h101, 32'h00000077, 32'h0,         0, 0, 4'b0010, 32'h77777777, 32'h0,         0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 3'b100, 32'h003, 32'h0,        32'hFE000000,  1, 1, 4'b1111, 32'h0,        32'h000000FE,  2));
`ifndef MEM_MISALIGN_TRAP_EN
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 3'b001, 32'h003, 32'h0,        32'hC0000000,  0, 1, 4'b1111, 32'h0,        32'hFFFFC000,  1));
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 3'b010, 32'h007, 32'h0,        32'h11223344,  0, 1, 4'b1111, 32'h0,        32'h11223344,  1));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 3'b001, 32'h101, 32'h00001234, 32'h0,         0, 0, 4'b0011, 32'h12341234, 32'h0,         0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 3'b010, 32'h106, 32'h89ABCDEF, 32'h0,         0, 0, 4'b1111, 32'h89ABCDEF, 32'h0,         0));
`endif

        foreach (vecs[i]) run_op(vecs[i], i);

        // Reset while waiting for load data, then a late rvalid.
        MemAddrIn = 32'h40; funct3In = 3'b010; MemRdEnIn = 1'b1; RegWrtEnIn = 1'b1;
        RegDstIn = 5'd9; DmRdata = 32'h5A5A5A5A; DmGnt = 1'b1;
        @(negedge clk);
        check("rstseq_req", 32'(DmReq), 1);
        check("rstseq_gnt_stall", 32'(MemStall), 1);
        @(posedge clk); #1;
        DmGnt = 1'b0;
        @(negedge clk);
        check("rstseq_wait_stall", 32'(MemStall), 1);
        check("rstseq_wait_req", 32'(DmReq), 0);
        #1 rst = 1'b0;
        #1;
        check("rstseq_stall", 32'(MemStall), 0);
        check("rstseq_req_low", 32'(DmReq), 0);
        check("rstseq_rwe", 32'(RegWrtEnOut), 0);
        check("rstseq_alu", ALUResultOut, 0);
        check("rstseq_rdata", RdDataOut, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        drive_idle();
        DmRvalid = 1'b1;
        @(negedge clk);
        check("rstseq_late_stall", 32'(MemStall), 0);
        @(posedge clk); #1;
        DmRvalid = 1'b0;
        @(negedge clk);
        check("rstseq_late_rwe", 32'(RegWrtEnOut), 0);
        check("rstseq_late_rdata", RdDataOut, 0);
        prev_alu = '0;
        @(posedge clk); #1;
        run_op(mk(1'b0, 1'b1, 1'b1, 3'b010, 32'h044, 32'h0, 32'h0F0F1234, 0, 1, 4'b1111, 32'h0, 32'h0F0F1234, 1), 40);

`ifdef MEM_MISALIGN_TRAP_EN
        // Misaligned LW: no request, no register write, one-cycle pulse.
        MemAddrIn = 32'h2; funct3In = 3'b010; MemRdEnIn = 1'b1; RegWrtEnIn = 1'b1; RegDstIn = 5'd3;
        @(negedge clk);
        check("trap_req", 32'(DmReq), 0);
        check("trap_stall", 32'(MemStall), 0);
        @(posedge clk); #1;
        drive_idle();
        @(negedge clk);
        check("trap_pulse", 32'(MisalignOut), 1);
        check("trap_rwe", 32'(RegWrtEnOut), 0);
        check("trap_alu", ALUResultOut, 32'h2);
        @(posedge clk); #1;
        @(negedge clk);
        check("trap_pulse_end", 32'(MisalignOut), 0);
`endif

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
